// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: unit selects, compare sub-ops
// and the issuer state encoding.
package alu_pkg;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

  localparam logic [1:0] CMP_NOP = 2'b00;
  localparam logic [1:0] CMP_EQ  = 2'b01;
  localparam logic [1:0] CMP_GT  = 2'b10;
  localparam logic [1:0] CMP_LT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command and result valid/ready channels of the ALU op issuer.
// master = upstream/downstream side, slave = the issuer itself.
interface alu_op_issuer_if #(
  parameter int WIDTH = 16,
  parameter int FUN_W = 4
) ();

  logic             CMD_VALID;
  logic             CMD_READY;
  logic [WIDTH-1:0] CMD_A;
  logic [WIDTH-1:0] CMD_B;
  logic [FUN_W-1:0] CMD_FUN;

  logic             RES_VALID;
  logic             RES_READY;
  logic [WIDTH-1:0] RES_DATA;
  logic [1:0]       RES_UNIT;
  logic             RES_ERR;

  modport master (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN, RES_READY,
    input  CMD_READY, RES_VALID, RES_DATA, RES_UNIT, RES_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN, RES_READY,
    output CMD_READY, RES_VALID, RES_DATA, RES_UNIT, RES_ERR
  );

endinterface

// File: rtl/alu_unit_decoder.sv
// Turns a unit select plus an issue strobe into one-hot unit enables
// (all zero when the strobe is low).
module alu_unit_decoder
  import alu_pkg::*;
(
  input  logic [1:0] unit_sel,
  input  logic       strobe,
  output logic       arith_en,
  output logic       logic_en,
  output logic       cmp_en,
  output logic       shift_en
);

  always_comb begin
    arith_en = 1'b0;
    logic_en = 1'b0;
    cmp_en   = 1'b0;
    shift_en = 1'b0;
    if (strobe) begin
      case (unit_sel)
        UNIT_ARITH: arith_en = 1'b1;
        UNIT_LOGIC: logic_en = 1'b1;
        UNIT_CMP:   cmp_en   = 1'b1;
        UNIT_SHIFT: shift_en = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Initiator for the four ALU execution units: latches a command, pulses one
// unit enable, captures that unit's registered result and hands it downstream.
module alu_op_issuer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FUN_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  alu_op_issuer_if.slave   bus,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [FUN_W-1:0] ALU_FUN,
  output logic             ARITH_EN,
  output logic             LOGIC_EN,
  output logic             CMP_EN,
  output logic             SHIFT_EN,
  input  logic [WIDTH-1:0] ARITH_OUT,
  input  logic [WIDTH-1:0] LOGIC_OUT,
  input  logic [WIDTH-1:0] CMP_OUT,
  input  logic [WIDTH-1:0] SHIFT_OUT,
  input  logic             ARITH_FLAG,
  input  logic             LOGIC_FLAG,
  input  logic             CMP_FLAG,
  input  logic             SHIFT_FLAG,
  output logic             BUSY
);

  state_t           state;
  logic             accept;
  logic             dec_arith, dec_logic, dec_cmp, dec_shift;
  logic [WIDTH-1:0] sel_out;
  logic [3:0]       flag_vec;
  logic [3:0]       sel_onehot;
  logic             flag_err;

  assign bus.CMD_READY = (state == ST_IDLE) || ((state == ST_HOLD) && bus.RES_READY);
  assign accept        = bus.CMD_VALID && bus.CMD_READY;

  // Enables are decoded from the incoming command so they can be registered
  // on the accept edge and be high exactly during ISSUE.
  alu_unit_decoder u_dec (
    .unit_sel (bus.CMD_FUN[3:2]),
    .strobe   (accept),
    .arith_en (dec_arith),
    .logic_en (dec_logic),
    .cmp_en   (dec_cmp),
    .shift_en (dec_shift)
  );

  // Error when the flag pattern is anything but "only the addressed unit".
  always_comb begin
    sel_out = ARITH_OUT;
    case (ALU_FUN[3:2])
      UNIT_ARITH: sel_out = ARITH_OUT;
      UNIT_LOGIC: sel_out = LOGIC_OUT;
      UNIT_CMP:   sel_out = CMP_OUT;
      UNIT_SHIFT: sel_out = SHIFT_OUT;
    endcase
    flag_vec   = {SHIFT_FLAG, CMP_FLAG, LOGIC_FLAG, ARITH_FLAG};
    sel_onehot = 4'b0001 << ALU_FUN[3:2];
    flag_err   = (flag_vec != sel_onehot);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state         <= ST_IDLE;
      ALU_A         <= '0;
      ALU_B         <= '0;
      ALU_FUN       <= '0;
      ARITH_EN      <= 1'b0;
      LOGIC_EN      <= 1'b0;
      CMP_EN        <= 1'b0;
      SHIFT_EN      <= 1'b0;
      bus.RES_VALID <= 1'b0;
      bus.RES_DATA  <= '0;
      bus.RES_UNIT  <= '0;
      bus.RES_ERR   <= 1'b0;
      BUSY          <= 1'b0;
    end else begin
      {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN} <= {dec_shift, dec_cmp, dec_logic, dec_arith};
      // accept can only be true in IDLE or HOLD, so the operand load is shared.
      if (accept) begin
        ALU_A   <= bus.CMD_A;
        ALU_B   <= bus.CMD_B;
        ALU_FUN <= bus.CMD_FUN;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_ISSUE;
            BUSY  <= 1'b1;
          end
        end
        ST_ISSUE: state <= ST_CAPTURE;
        ST_CAPTURE: begin
          bus.RES_DATA  <= sel_out;
          bus.RES_UNIT  <= ALU_FUN[3:2];
          bus.RES_ERR   <= flag_err;
          bus.RES_VALID <= 1'b1;
          state         <= ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.RES_READY) begin
            bus.RES_VALID <= 1'b0;
            if (bus.CMD_VALID) begin
              state <= ST_ISSUE;
            end else begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
